// File: rtl/sdrd_reqarb_if.sv
// sdrd_reqarb_if: requester, SPI controller and status signals of sdrd_reqarb; ERR exists only with SDRD_ARB_TIMEOUT_EN
interface sdrd_reqarb_if;
   logic        REQ0_VALID;
   logic [31:0] REQ0_ADR;
   logic [31:0] REQ0_SIZE;
   logic        REQ0_ACK;
   logic        REQ0_DONE;
   logic        REQ1_VALID;
   logic [31:0] REQ1_ADR;
   logic [31:0] REQ1_SIZE;
   logic        REQ1_ACK;
   logic        REQ1_DONE;
   logic        SPI_BUSY;
   logic        SPI_INIT;
   logic [31:0] SPIN_ACCESS_ADR;
   logic [31:0] SPIN_ACCESS_SIZE;
   logic [1:0]  SPIN_DATATYPE;
   logic [1:0]  GRANT;
`ifdef SDRD_ARB_TIMEOUT_EN
   logic        ERR;
`endif
   modport master (
      output REQ0_VALID, REQ0_ADR, REQ0_SIZE, REQ1_VALID, REQ1_ADR, REQ1_SIZE, SPI_BUSY, SPI_INIT,
      input  REQ0_ACK, REQ0_DONE, REQ1_ACK, REQ1_DONE, SPIN_ACCESS_ADR, SPIN_ACCESS_SIZE, SPIN_DATATYPE, GRANT
`ifdef SDRD_ARB_TIMEOUT_EN
      , input ERR
`endif
   );
   modport slave (
      input  REQ0_VALID, REQ0_ADR, REQ0_SIZE, REQ1_VALID, REQ1_ADR, REQ1_SIZE, SPI_BUSY, SPI_INIT,
      output REQ0_ACK, REQ0_DONE, REQ1_ACK, REQ1_DONE, SPIN_ACCESS_ADR, SPIN_ACCESS_SIZE, SPIN_DATATYPE, GRANT
`ifdef SDRD_ARB_TIMEOUT_EN
      , output ERR
`endif
   );
endinterface

// File: rtl/sdrd_reqarb.sv
// sdrd_reqarb: round-robin arbiter that splits requests into sector-sized SD SPI reads; SDRD_ARB_TIMEOUT_EN adds a WAIT_DONE timeout and ERR
module sdrd_reqarb #(
   parameter int unsigned MAX_CHUNK = 512,
   parameter int unsigned BUSY_WAIT = 16,
   parameter int unsigned TIMEOUT   = 1000000
) (
   input logic          CLK,
   input logic          RST,
   sdrd_reqarb_if.slave bus
);
   typedef enum logic [2:0] {WAIT_RDY, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, FINISH} state_t;
   state_t      state, state_n;
   logic        last, pick, grab, step, fin, tmo;
   logic [1:0]  owner, ack, done, dt;
   logic [31:0] cur_adr, remain, cnt, adr_r, size_r, req_size;

   assign pick             = (bus.REQ0_VALID && bus.REQ1_VALID) ? ~last : bus.REQ1_VALID;
   assign req_size         = pick ? bus.REQ1_SIZE : bus.REQ0_SIZE;
   assign fin              = (state == FINISH) || tmo;
   assign bus.REQ0_ACK     = ack[0];
   assign bus.REQ1_ACK     = ack[1];
   assign bus.REQ0_DONE    = done[0];
   assign bus.REQ1_DONE    = done[1];
   assign bus.SPIN_ACCESS_ADR  = adr_r;
   assign bus.SPIN_ACCESS_SIZE = size_r;
   assign bus.SPIN_DATATYPE    = dt;
   assign bus.GRANT            = owner;

`ifdef SDRD_ARB_TIMEOUT_EN
   logic [31:0] tcnt;
   logic        err;
   assign tmo     = (state == WAIT_DONE) && (tcnt == TIMEOUT - 1);
   assign bus.ERR = err;
   // cycles spent waiting for the current chunk, and the sticky timeout flag
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tcnt <= '0;
         err  <= 1'b0;
      end else begin
         tcnt <= (state == WAIT_DONE) ? tcnt + 32'd1 : 32'd0;
         if (tmo) err <= 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
`endif

   // state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= WAIT_RDY;
      else     state <= state_n;
   end

   // next state plus the grant and chunk-complete decisions
   always_comb begin
      state_n = state;
      grab    = 1'b0;
      step    = 1'b0;
      case (state)
         WAIT_RDY:  if (!bus.SPI_INIT && !bus.SPI_BUSY) state_n = (owner != 2'b00) ? ISSUE : IDLE;
         IDLE:      if (bus.REQ0_VALID || bus.REQ1_VALID) begin
                       grab    = 1'b1;
                       state_n = (req_size == 32'd0) ? FINISH : ISSUE;
                    end
         ISSUE:     state_n = WAIT_BUSY;
         WAIT_BUSY: state_n = bus.SPI_INIT ? WAIT_RDY : bus.SPI_BUSY ? WAIT_DONE :
                              (cnt == BUSY_WAIT - 1) ? ISSUE : WAIT_BUSY;
         WAIT_DONE: if (tmo) state_n = IDLE;
                    else if (bus.SPI_INIT) state_n = WAIT_RDY;
                    else if (!bus.SPI_BUSY) begin
                       step    = 1'b1;
                       state_n = (remain == size_r) ? FINISH : ISSUE;
                    end
         FINISH:    state_n = IDLE;
         default:   state_n = WAIT_RDY;
      endcase
   end

   // request latch, chunk registers, handshake pulses and round-robin pointer
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last    <= 1'b1;
         owner   <= '0;
         ack     <= '0;
         done    <= '0;
         dt      <= '0;
         cur_adr <= '0;
         remain  <= '0;
         cnt     <= '0;
         adr_r   <= '0;
         size_r  <= '0;
      end else begin
         ack  <= grab ? (pick ? 2'b10 : 2'b01) : 2'b00;
         done <= fin ? owner : 2'b00;
         dt   <= (state == ISSUE) ? (owner[1] ? 2'd2 : 2'd1) : 2'd0;
         cnt  <= (state == WAIT_BUSY) ? cnt + 32'd1 : 32'd0;
         if (grab) begin
            last    <= pick;
            owner   <= pick ? 2'b10 : 2'b01;
            cur_adr <= pick ? bus.REQ1_ADR : bus.REQ0_ADR;
            remain  <= req_size;
         end else if (fin) begin
            owner <= 2'b00;
         end
         if (state == ISSUE) begin
            adr_r  <= cur_adr;
            size_r <= (remain < 32'(MAX_CHUNK)) ? remain : 32'(MAX_CHUNK);
         end
         if (step) begin
            cur_adr <= cur_adr + size_r;
            remain  <= remain - size_r;
         end
      end
   end
endmodule

// File: tb/tb_sdrd_reqarb.sv
// tb_sdrd_reqarb: directed vector table plus hand sequences for contention, re-init, missed BUSY, reset abort and timeout
module tb_sdrd_reqarb;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   sdrd_reqarb_if bus();
   sdrd_reqarb #(.MAX_CHUNK(512), .BUSY_WAIT(16), .TIMEOUT(100)) dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   typedef struct {
      logic        who;
      logic [31:0] adr;
      logic [31:0] size;
      int          n;
      logic [31:0] fa;
      logic [31:0] fs;
      logic [31:0] la;
      logic [31:0] ls;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          busy_left = 0;
   bit          auto_busy = 1'b0;
   int          ack_q[$];
   int          done_q[$];
   logic [31:0] iss_adr[$];
   logic [31:0] iss_size[$];
   logic [1:0]  iss_dt[$];
   logic [1:0]  gnt_at_ack, gnt_at_done;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // one clock: sample outputs just after the edge and play the SPI controller
   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
      if (bus.SPIN_DATATYPE != 2'd0) begin
         iss_adr.push_back(bus.SPIN_ACCESS_ADR);
         iss_size.push_back(bus.SPIN_ACCESS_SIZE);
         iss_dt.push_back(bus.SPIN_DATATYPE);
      end
      if (bus.REQ0_ACK) begin ack_q.push_back(0); gnt_at_ack = bus.GRANT; end
      if (bus.REQ1_ACK) begin ack_q.push_back(1); gnt_at_ack = bus.GRANT; end
      if (bus.REQ0_DONE) begin done_q.push_back(0); gnt_at_done = bus.GRANT; end
      if (bus.REQ1_DONE) begin done_q.push_back(1); gnt_at_done = bus.GRANT; end
      if (auto_busy) begin
         if (bus.SPIN_DATATYPE != 2'd0) busy_left = 10;
         bus.SPI_BUSY = (busy_left != 0);
         if (busy_left != 0) busy_left--;
      end
   endtask

   task automatic clear();
      ack_q.delete();
      done_q.delete();
      iss_adr.delete();
      iss_size.delete();
      iss_dt.delete();
      busy_left   = 0;
      gnt_at_ack  = 2'bxx;
      gnt_at_done = 2'bxx;
   endtask

   function automatic int cnt_of(input int sel);
      return (sel == 0) ? ack_q.size() : (sel == 1) ? done_q.size() : iss_adr.size();
   endfunction

   function automatic logic [31:0] at_a(input int i);
      return (i < iss_adr.size()) ? iss_adr[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] at_s(input int i);
      return (i < iss_size.size()) ? iss_size[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] at_k(input int i);
      return (i < ack_q.size()) ? 32'(ack_q[i]) : 32'hDEAD_BEEF;
   endfunction

   // sel: 0 = acks, 1 = dones, 2 = issues
   task automatic wait_n(input int sel, input int tgt, input int budget, output int took);
      took = 0;
      while (cnt_of(sel) < tgt && took < budget) begin
         tick();
         took++;
      end
      if (cnt_of(sel) < tgt) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_%0d: reached %0d of %0d within %0d cycles", sel, cnt_of(sel), tgt, budget);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      bus.SPI_BUSY   = 1'b0;
      bus.SPI_INIT   = 1'b0;
      bus.REQ0_VALID = 1'b0;
      bus.REQ1_VALID = 1'b0;
      tick();
      chk("rst_ctl", {24'd0, bus.REQ0_ACK, bus.REQ0_DONE, bus.REQ1_ACK, bus.REQ1_DONE, bus.SPIN_DATATYPE, bus.GRANT}, 32'd0);
      RST = 1'b0;
      tick();
      tick();
      clear();
   endtask

   initial begin
      vec_t vt[6];
      int   took, c1, c2;
      vt[0] = '{1'b0, 32'h1000, 32'd64, 1, 32'h1000, 32'd64, 32'h1000, 32'd64};
      vt[1] = '{1'b1, 32'h2000, 32'd1300, 3, 32'h2000, 32'd512, 32'h2400, 32'd276};
      vt[2] = '{1'b0, 32'h4000, 32'd0, 0, 32'd0, 32'd0, 32'd0, 32'd0};
      vt[3] = '{1'b1, 32'h5000, 32'd512, 1, 32'h5000, 32'd512, 32'h5000, 32'd512};
      vt[4] = '{1'b0, 32'hFFFF_FF00, 32'd1024, 2, 32'hFFFF_FF00, 32'd512, 32'h0000_0100, 32'd512};
      vt[5] = '{1'b0, 32'h10, 32'd513, 2, 32'h10, 32'd512, 32'h210, 32'd1};
      bus.REQ0_VALID = 1'b0;
      bus.REQ1_VALID = 1'b0;
      bus.REQ0_ADR   = '0;
      bus.REQ0_SIZE  = '0;
      bus.REQ1_ADR   = '0;
      bus.REQ1_SIZE  = '0;
      bus.SPI_BUSY   = 1'b0;
      bus.SPI_INIT   = 1'b0;
      tick();
      chk("rst_adr", bus.SPIN_ACCESS_ADR, 32'd0);
      chk("rst_size", bus.SPIN_ACCESS_SIZE, 32'd0);
      do_reset();

      for (int i = 0; i < 6; i++) begin
         clear();
         auto_busy = 1'b1;
         if (vt[i].who) begin
            bus.REQ1_VALID = 1'b1;
            bus.REQ1_ADR   = vt[i].adr;
            bus.REQ1_SIZE  = vt[i].size;
         end else begin
            bus.REQ0_VALID = 1'b1;
            bus.REQ0_ADR   = vt[i].adr;
            bus.REQ0_SIZE  = vt[i].size;
         end
         wait_n(0, 1, 20, took);
         chk($sformatf("v%0d_ack_lat", i), took, 1);
         chk($sformatf("v%0d_ack_who", i), at_k(0), 32'(vt[i].who));
         chk($sformatf("v%0d_ack_grant", i), gnt_at_ack, vt[i].who ? 32'd2 : 32'd1);
         bus.REQ0_VALID = 1'b0;
         bus.REQ1_VALID = 1'b0;
         wait_n(1, 1, 3000, took);
         chk($sformatf("v%0d_n_issue", i), iss_adr.size(), vt[i].n);
         if (vt[i].n > 0) begin
            chk($sformatf("v%0d_dt", i), iss_dt[0], vt[i].who ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_first_adr", i), at_a(0), vt[i].fa);
            chk($sformatf("v%0d_first_size", i), at_s(0), vt[i].fs);
            chk($sformatf("v%0d_last_adr", i), at_a(vt[i].n - 1), vt[i].la);
            chk($sformatf("v%0d_last_size", i), at_s(vt[i].n - 1), vt[i].ls);
         end
         chk($sformatf("v%0d_done_who", i), (done_q.size() > 0) ? 32'(done_q[0]) : 32'hDEAD_BEEF, 32'(vt[i].who));
         chk($sformatf("v%0d_done_grant", i), gnt_at_done, 32'd0);
         repeat (3) tick();
         chk($sformatf("v%0d_acks", i), ack_q.size(), 1);
         chk($sformatf("v%0d_dones", i), done_q.size(), 1);
      end

      // both requesters held valid: grants must alternate starting with requester 0
      do_reset();
      auto_busy = 1'b1;
      bus.REQ0_ADR   = 32'h100;
      bus.REQ0_SIZE  = 32'd64;
      bus.REQ1_ADR   = 32'h200;
      bus.REQ1_SIZE  = 32'd64;
      bus.REQ0_VALID = 1'b1;
      bus.REQ1_VALID = 1'b1;
      wait_n(0, 4, 1000, took);
      bus.REQ0_VALID = 1'b0;
      bus.REQ1_VALID = 1'b0;
      wait_n(1, 4, 1000, took);
      for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d", k), at_k(k), 32'(k % 2));
      chk("rr_dones", done_q.size(), 4);

      // card re-initialises during chunk 2: chunk 2 must be re-read
      do_reset();
      auto_busy = 1'b0;
      bus.REQ1_ADR   = 32'h2000;
      bus.REQ1_SIZE  = 32'd1300;
      bus.REQ1_VALID = 1'b1;
      wait_n(0, 1, 20, took);
      bus.REQ1_VALID = 1'b0;
      wait_n(2, 1, 40, took);
      bus.SPI_BUSY = 1'b1;
      repeat (10) tick();
      bus.SPI_BUSY = 1'b0;
      wait_n(2, 2, 40, took);
      chk("ri_c2_adr", at_a(1), 32'h2200);
      bus.SPI_BUSY = 1'b1;
      tick();
      bus.SPI_INIT = 1'b1;
      repeat (20) tick();
      chk("ri_no_issue_in_init", iss_adr.size(), 2);
      bus.SPI_BUSY = 1'b0;
      bus.SPI_INIT = 1'b0;
      auto_busy = 1'b1;
      wait_n(2, 3, 60, took);
      chk("ri_reissue_adr", at_a(2), 32'h2200);
      chk("ri_reissue_size", at_s(2), 32'd512);
      wait_n(1, 1, 2000, took);
      chk("ri_n_issue", iss_adr.size(), 4);
      chk("ri_last_adr", at_a(3), 32'h2400);
      chk("ri_last_size", at_s(3), 32'd276);
      chk("ri_dones", done_q.size(), 1);

      // BUSY never rises: same chunk every BUSY_WAIT+1 cycles, then reset aborts without DONE
      do_reset();
      auto_busy = 1'b0;
      bus.REQ0_ADR   = 32'h3000;
      bus.REQ0_SIZE  = 32'd100;
      bus.REQ0_VALID = 1'b1;
      wait_n(0, 1, 20, took);
      bus.REQ0_VALID = 1'b0;
      wait_n(2, 1, 40, took);
      c1 = cyc;
      wait_n(2, 2, 40, took);
      c2 = cyc;
      chk("mb_period1", c2 - c1, 17);
      wait_n(2, 3, 40, took);
      chk("mb_period2", cyc - c2, 17);
      chk("mb_adr", at_a(2), 32'h3000);
      chk("mb_size", at_s(2), 32'd100);
      RST = 1'b1;
      tick();
      chk("ab_grant", bus.GRANT, 32'd0);
      RST = 1'b0;
      clear();
      repeat (40) tick();
      chk("ab_dones", done_q.size(), 0);
      chk("ab_issues", iss_adr.size(), 0);

`ifdef SDRD_ARB_TIMEOUT_EN
      // BUSY stuck high: DONE and ERR after TIMEOUT cycles in WAIT_DONE
      do_reset();
      auto_busy = 1'b0;
      bus.REQ0_ADR   = 32'h100;
      bus.REQ0_SIZE  = 32'd64;
      bus.REQ0_VALID = 1'b1;
      wait_n(0, 1, 20, took);
      bus.REQ0_VALID = 1'b0;
      wait_n(2, 1, 40, took);
      bus.SPI_BUSY = 1'b1;
      wait_n(1, 1, 300, took);
      chk("to_latency", took, 101);
      chk("to_err", bus.ERR, 32'd1);
      chk("to_grant", gnt_at_done, 32'd0);
      repeat (5) tick();
      chk("to_err_sticky", bus.ERR, 32'd1);
      bus.SPI_BUSY = 1'b0;
      RST = 1'b1;
      tick();
      chk("to_err_clear", bus.ERR, 32'd0);
      RST = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
